// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: line-granular backing memory for the data cache's 256-bit
// memory port. Each request is served after a fixed latency and completed
// with a one-cycle ack pulse. Only one request is outstanding at a time.
//
// Optional build macro: LINE_MEM_STATS_EN adds read/write commit counters
// (rd_count_o, wr_count_o).
module line_mem_ctrl #(
  parameter int DEPTH   = 512,  // number of 256-bit lines, power of two
  parameter int LATENCY = 10    // cycles from acceptance to ack, 1..255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_enable_i,
  input  logic         mem_write_i,
  input  logic [31:0]  mem_addr_i,
  input  logic [255:0] mem_data_i,
  output logic         mem_ack_o,
  output logic [255:0] mem_data_o,
  output logic         busy_o
`ifdef LINE_MEM_STATS_EN
  ,
  output logic [31:0]  rd_count_o,
  output logic [31:0]  wr_count_o
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t             state;
  logic [7:0]         cnt;
  logic [IDX_W-1:0]   req_idx;
  logic               req_wr;
  logic [255:0]       req_data;

  logic [255:0]       mem [DEPTH];

  // Line index from the byte address; offset and high bits are dropped,
  // so addresses alias modulo DEPTH lines.
  logic [IDX_W-1:0]   addr_idx;
  assign addr_idx = mem_addr_i[4+IDX_W:5];

  // Address bits that do not select a line are intentionally unused.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr_i[31:5+IDX_W], mem_addr_i[4:0]};

  // The access happens on the last WAIT edge; a reset forces IDLE at once,
  // which drops this strobe and keeps an aborted write from committing.
  logic commit;
  assign commit = (state == S_WAIT) && (cnt == 8'd0);

  // Line storage: written only when a latched write request commits.
  // NOTE: the array has no reset branch on purpose; resetting a RAM would
  // turn it into thousands of flops, and its contents are never assumed.
  always_ff @(posedge clk_i) begin
    if (commit && req_wr) begin
      mem[req_idx] <= req_data;
    end
  end

  // Request FSM: accept in IDLE, count down in WAIT, pulse ack in ACK.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register here sees the pre-edge value of every other register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      req_idx    <= '0;
      req_wr     <= 1'b0;
      req_data   <= '0;
      mem_ack_o  <= 1'b0;
      mem_data_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      mem_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_enable_i) begin
            req_idx  <= addr_idx;
            req_wr   <= mem_write_i;
            req_data <= mem_data_i;
            cnt      <= 8'(LATENCY - 1);
            busy_o   <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 8'd0) begin
            if (!req_wr) begin
              mem_data_o <= mem[req_idx];
            end
            mem_ack_o <= 1'b1;
            state     <= S_ACK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_ACK: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

`ifdef LINE_MEM_STATS_EN
  // Commit counters; they wrap naturally at 32 bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_count_o <= 32'd0;
      wr_count_o <= 32'd0;
    end else if (commit) begin
      if (req_wr) begin
        wr_count_o <= wr_count_o + 32'd1;
      end else begin
        rd_count_o <= rd_count_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb_line_mem_ctrl: directed bench for line_mem_ctrl with a timing/contents
// model (acceptance cycle + LATENCY arithmetic, associative line store)
// checked every cycle, plus hand-computed literal expectations.
module tb_line_mem_ctrl;

  localparam int DEPTH = 512;
  localparam int LAT   = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         en, wr;
  logic [31:0]  addr;
  logic [255:0] wdata;
  logic         ack, busy;
  logic [255:0] rdata;

  // Second instance with the minimum latency.
  logic         en2, wr2;
  logic [31:0]  addr2;
  logic [255:0] wdata2;
  logic         ack2, busy2;
  logic [255:0] rdata2;

`ifdef LINE_MEM_STATS_EN
  logic [31:0]  rd_cnt, wr_cnt, rd_cnt2, wr_cnt2;
`endif

  always #5 clk = ~clk;

  line_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_enable_i(en), .mem_write_i(wr), .mem_addr_i(addr), .mem_data_i(wdata),
    .mem_ack_o(ack), .mem_data_o(rdata), .busy_o(busy)
`ifdef LINE_MEM_STATS_EN
    , .rd_count_o(rd_cnt), .wr_count_o(wr_cnt)
`endif
  );

  line_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .mem_enable_i(en2), .mem_write_i(wr2), .mem_addr_i(addr2), .mem_data_i(wdata2),
    .mem_ack_o(ack2), .mem_data_o(rdata2), .busy_o(busy2)
`ifdef LINE_MEM_STATS_EN
    , .rd_count_o(rd_cnt2), .wr_count_o(wr_cnt2)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [255:0] mdl_mem [int];
  bit           mdl_on = 0;
  int           cyc = 0;
  bit           act_q = 0, was_act;
  int           acc_cyc;
  bit           a_wr;
  int           a_idx;
  logic [255:0] a_data;
  bit           exp_ack, exp_busy, exp_data_ok;
  logic [255:0] exp_data;
  int           exp_rd, exp_wr;

  function automatic int line_of(input logic [31:0] a);
    return int'((a % 32'(DEPTH * 32)) / 32);
  endfunction

  // A request accepted at cycle c commits and acks at c+LAT, frees at c+LAT+1.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q = 0; exp_ack = 0; exp_busy = 0;
      exp_data = '0; exp_data_ok = 1; exp_rd = 0; exp_wr = 0;
    end else begin
      cyc++;
      was_act = act_q;
      exp_ack = 0;
      if (act_q && cyc == acc_cyc + LAT) begin
        exp_ack = 1;
        if (a_wr) begin
          mdl_mem[a_idx] = a_data;
          exp_wr++;
        end else begin
          exp_rd++;
          if (mdl_mem.exists(a_idx)) begin
            exp_data = mdl_mem[a_idx];
            exp_data_ok = 1;
          end else begin
            exp_data_ok = 0;
          end
        end
      end else if (act_q && cyc == acc_cyc + LAT + 1) begin
        act_q = 0;
      end
      if (!was_act && en) begin
        act_q = 1; acc_cyc = cyc; a_wr = wr; a_idx = line_of(addr); a_data = wdata;
      end
      exp_busy = act_q;
    end
  end

  // Compare process: every cycle, away from the clock edge.
  always @(posedge clk) begin
    #1;
    if (mdl_on && !rst) begin
      check("ack", {255'b0, ack}, {255'b0, exp_ack});
      check("busy", {255'b0, busy}, {255'b0, exp_busy});
      if (exp_data_ok) check("rdata", rdata, exp_data);
`ifdef LINE_MEM_STATS_EN
      check("rd_count", {224'b0, rd_cnt}, 256'(exp_rd));
      check("wr_count", {224'b0, wr_cnt}, 256'(exp_wr));
`endif
    end
  end

  // ---------------- stimulus ----------------
  int lat_seen, busy_seen;

  // Issue one request from idle and hold enable until ack; report the
  // number of edges from acceptance to ack and the busy cycles observed.
  task automatic do_req(input bit w, input logic [31:0] a, input logic [255:0] d,
                        output int lat, output int bsy);
    bit got = 0;
    @(negedge clk);
    en = 1; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    lat = 0;
    bsy = busy ? 1 : 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bsy++;
      if (ack) got = 1;
    end
    if (!got) check("ack_timeout", 256'd0, 256'd1);
    @(negedge clk);
    en = 0;
  endtask

  logic [255:0] pat_a5, pat_11, pat_3c, pat_ff, pat_77;
  int ack_t[2];
  int nack, ack_hi;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_11 = {32{8'h11}};
    pat_3c = {32{8'h3C}};
    pat_ff = {32{8'hFF}};
    pat_77 = {32{8'h77}};
    rst = 1; en = 0; wr = 0; addr = '0; wdata = '0;
    en2 = 0; wr2 = 0; addr2 = '0; wdata2 = '0;
    repeat (3) @(negedge clk);
    check("reset_ack", {255'b0, ack}, 256'd0);
    check("reset_busy", {255'b0, busy}, 256'd0);
    check("reset_rdata", rdata, 256'd0);
    rst = 0;
    mdl_on = 1;

    // Write A5 line, then read it back through a different offset.
    do_req(1, 32'h0000_0040, pat_a5, lat_seen, busy_seen);
    check("wr_latency", 256'(lat_seen), 256'd10);
    check("wr_busy_cycles", 256'(busy_seen), 256'd11);
    do_req(0, 32'h0000_005C, 256'd0, lat_seen, busy_seen);
    check("rd_latency", 256'(lat_seen), 256'd10);
    check("rd_data_a5", rdata, pat_a5);
    repeat (3) @(posedge clk);
    #1 check("rd_data_hold", rdata, pat_a5);

    // Never-written line: data is don't-care.
    do_req(0, 32'h0000_0080, 256'd0, lat_seen, busy_seen);

    // Address wrap: 0x4040 aliases 0x40 with 512 lines.
    do_req(1, 32'h0000_4040, pat_11, lat_seen, busy_seen);
    do_req(0, 32'h0000_0040, 256'd0, lat_seen, busy_seen);
    check("wrap_data", rdata, pat_11);

    // Held enable, address changes mid-WAIT; two acks LAT+2 apart.
    @(negedge clk);
    en = 1; wr = 0; addr = 32'h0000_0040;
    nack = 0;
    for (int i = 0; i < 100 && nack < 2; i++) begin
      @(posedge clk); #1;
      if (i == 3) addr = 32'h0000_0060;
      if (ack) begin
        if (nack == 0) check("held_first_data", rdata, pat_11);
        ack_t[nack] = i;
        nack++;
      end
    end
    check("held_ack_count", 256'(nack), 256'd2);
    if (nack == 2) check("held_ack_spacing", 256'(ack_t[1] - ack_t[0]), 256'd12);
    @(negedge clk);
    en = 0;
    repeat (2) @(negedge clk);

    // Reset aborts an in-flight write.
    do_req(1, 32'h0000_0020, pat_3c, lat_seen, busy_seen);
    @(negedge clk);
    en = 1; wr = 1; addr = 32'h0000_0020; wdata = pat_ff;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    check("abort_busy", {255'b0, busy}, 256'd0);
    check("abort_ack", {255'b0, ack}, 256'd0);
    @(negedge clk);
    en = 0;
    @(negedge clk);
    rst = 0;
    ack_hi = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (ack) ack_hi++;
    end
    check("abort_no_ack", 256'(ack_hi), 256'd0);
    do_req(0, 32'h0000_0020, 256'd0, lat_seen, busy_seen);
    check("abort_prior_data", rdata, pat_3c);

`ifdef LINE_MEM_STATS_EN
    // Fresh counter run: two writes and two reads.
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    do_req(1, 32'h0000_0100, pat_77, lat_seen, busy_seen);
    do_req(1, 32'h0000_0120, pat_a5, lat_seen, busy_seen);
    do_req(0, 32'h0000_0100, 256'd0, lat_seen, busy_seen);
    do_req(0, 32'h0000_0120, 256'd0, lat_seen, busy_seen);
    check("stats_wr", {224'b0, wr_cnt}, 256'd2);
    check("stats_rd", {224'b0, rd_cnt}, 256'd2);
`endif

    // LATENCY=1 instance: ack one edge after acceptance.
    @(negedge clk);
    en2 = 1; wr2 = 1; addr2 = 32'h0000_0040; wdata2 = pat_77;
    @(posedge clk); #1;
    check("l1_accept_ack", {255'b0, ack2}, 256'd0);
    check("l1_accept_busy", {255'b0, busy2}, 256'd1);
    @(posedge clk); #1;
    check("l1_wr_ack", {255'b0, ack2}, 256'd1);
    @(negedge clk);
    en2 = 0;
    @(posedge clk); #1;
    check("l1_idle_ack", {255'b0, ack2}, 256'd0);
    check("l1_idle_busy", {255'b0, busy2}, 256'd0);
    @(negedge clk);
    en2 = 1; wr2 = 0; addr2 = 32'h0000_0044;
    @(posedge clk);
    @(posedge clk); #1;
    check("l1_rd_ack", {255'b0, ack2}, 256'd1);
    check("l1_rd_data", rdata2, pat_77);
    @(negedge clk);
    en2 = 0;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
